sseg_scan_driver: RTL and testbench

//  Time-multiplexed driver for an NDIGITS common-anode 7-segment display.
//  - Latches a packed BCD word and scans one digit per refresh slot.
//  - Decodes each digit to active-low segments and drives one active-low anode at a time.
//  - Sits between the value-producing logic (counters/ALU) and the board display pins.

---
 rtl/sseg_scan_driver_pkg.sv | 26 ++
 rtl/sseg_defs.vh | 34 +++
 rtl/sseg_glyph.sv | 16 +
 rtl/sseg_scan_driver.sv | 113 +++++++++++
 tb/tb_sseg_scan_driver.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/sseg_scan_driver_pkg.sv
// Shared segment constants and the full 16-entry glyph table for the scan driver.
package sseg_scan_driver_pkg;
`include "sseg_defs.vh"

  function automatic logic [6:0] glyph_of(input logic [3:0] code);
    case (code)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sseg_defs.vh
// Segment constants for the scan driver: bit order {a,b,c,d,e,f,g}, all active-low.
`ifndef SSEG_DEFS_VH
`define SSEG_DEFS_VH

  // Bit 6 is segment a, bit 0 is segment g.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_bits_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;

`endif

// File: rtl/sseg_glyph.sv
// Combinational 4-bit code to active-low segment decoder.
// `HEX_DIGITS_EN shows A-F for codes 10-15; otherwise those codes are blanked.
module sseg_glyph
  import sseg_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

`ifdef HEX_DIGITS_EN
  assign seg = glyph_of(code);
`else
  assign seg = (code > 4'd9) ? SEG_BLANK : glyph_of(code);
`endif

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with tear-free updates and leading-zero blanking.
// Build option `HEX_DIGITS_EN (in sseg_glyph) selects hex glyphs for codes 10-15.
module sseg_scan_driver
  import sseg_scan_driver_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NDIGITS-1:0] bcd_in,
  input  logic [NDIGITS-1:0]   dp_in,
  input  logic                 load,
  input  logic                 blank_lz,
  output logic [6:0]           sseg,
  output logic                 dp,
  output logic [NDIGITS-1:0]   an,
  output logic                 frame
);

  localparam int IDX_W = $clog2(NDIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]     presc;
  logic [IDX_W-1:0]     idx;
  logic [4*NDIGITS-1:0] pend_bcd;
  logic [4*NDIGITS-1:0] act_bcd;
  logic [NDIGITS-1:0]   pend_dp;
  logic [NDIGITS-1:0]   act_dp;
  logic                 pend_vld;
  logic                 slot_end;
  logic                 wrap;
  logic [NDIGITS-1:0]   lz_mask;
  logic                 zero_run;
  logic [3:0]           cur_digit;
  logic                 cur_dp;
  logic                 cur_blank;
  logic [6:0]           cur_seg;

  assign slot_end = (presc == LAST_CNT);
  assign wrap     = slot_end && (idx == LAST_IDX);

  // Digit k is a leading zero when it and every digit to its left are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (act_bcd[4*k +: 4] == 4'd0);
      lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = act_bcd[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = lz_mask[i];
      end
    end
  end

  sseg_glyph u_glyph (
    .code (cur_digit),
    .seg  (cur_seg)
  );

  // load is a one-cycle strobe with no back-pressure: it always lands in pending,
  // and pending moves to active only at the frame wrap, so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      idx      <= '0;
      pend_bcd <= '0;
      pend_dp  <= '0;
      act_bcd  <= '0;
      act_dp   <= '0;
      pend_vld <= 1'b0;
      sseg     <= SEG_BLANK;
      dp       <= 1'b1;
      an       <= '1;
      frame    <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      frame <= wrap;

      if (wrap && pend_vld) begin
        act_bcd <= pend_bcd;
        act_dp  <= pend_dp;
      end
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end else if (wrap) begin
        pend_vld <= 1'b0;
      end

      sseg <= (blank_lz && cur_blank) ? SEG_BLANK : cur_seg;
      dp   <= ~cur_dp;
      an   <= ~(NDIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver (NDIGITS=4, REFRESH_DIV=4); expectations follow `HEX_DIGITS_EN.
module tb_sseg_scan_driver;

  localparam int NDIGITS     = 4;
  localparam int REFRESH_DIV = 4;
  localparam int CNT_W       = 16;

  localparam logic [6:0] G0  = 7'b0000001;
  localparam logic [6:0] G1  = 7'b1001111;
  localparam logic [6:0] G2  = 7'b0010010;
  localparam logic [6:0] G3  = 7'b0000110;
  localparam logic [6:0] G4  = 7'b1001100;
  localparam logic [6:0] G5  = 7'b0100100;
  localparam logic [6:0] G6  = 7'b0100000;
  localparam logic [6:0] G7  = 7'b0001111;
  localparam logic [6:0] G8  = 7'b0000000;
  localparam logic [6:0] G9  = 7'b0000100;
  localparam logic [6:0] GBL = 7'b1111111;
`ifdef HEX_DIGITS_EN
  localparam logic [6:0] GA  = 7'b0001000;
  localparam logic [6:0] GF  = 7'b0111000;
`else
  localparam logic [6:0] GA  = GBL;
  localparam logic [6:0] GF  = GBL;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [4*NDIGITS-1:0] bcd_in = '0;
  logic [NDIGITS-1:0]   dp_in = '0;
  logic                 load = 1'b0;
  logic                 blank_lz = 1'b0;
  logic [6:0]           sseg;
  logic                 dp;
  logic [NDIGITS-1:0]   an;
  logic                 frame;

  int n_vec = 0;
  int n_err = 0;
  // {frame, an[3:0], dp, sseg[6:0]} expected per cycle of a frame
  logic [12:0] exp_q[$];

  sseg_scan_driver #(
    .NDIGITS     (NDIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .sseg     (sseg),
    .dp       (dp),
    .an       (an),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] v);
    bcd_in = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".frame_wait"}, 32'(frame), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".sseg"},  32'(sseg),  32'(GBL));
    check({tag, ".dp"},    32'(dp),    32'd1);
    check({tag, ".an"},    32'(an),    32'hF);
    check({tag, ".frame"}, 32'(frame), 32'd0);
  endtask

  // Check one full frame; optional loads at cycle la / lb of that frame (-1 = none).
  task automatic check_frame(input string tag, input logic [27:0] exp_seg,
                             input logic [3:0] exp_dp,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
    logic [12:0] e;
    wait_frame(tag);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back({(s == 3 && c == 3), ~(4'b0001 << s), exp_dp[s], exp_seg[7*s +: 7]});
      end
    end
    for (int c = 1; c <= 16; c++) begin
      if (c == la) begin
        bcd_in = va;
        load   = 1'b1;
      end else if (c == lb) begin
        bcd_in = vb;
        load   = 1'b1;
      end
      tick();
      load = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s.c%0d.an", tag, c),    32'(an),    32'(e[11:8]));
      check($sformatf("%s.c%0d.sseg", tag, c),  32'(sseg),  32'(e[6:0]));
      check($sformatf("%s.c%0d.dp", tag, c),    32'(dp),    32'(e[7]));
      check($sformatf("%s.c%0d.frame", tag, c), 32'(frame), 32'(e[12]));
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");

    rst = 1'b0;
    tick();
    check("release.an",   32'(an),   32'b1110);
    check("release.sseg", 32'(sseg), 32'(G0));

    load_word(16'h1234);
    check_frame("scan1",  {G1, G2, G3, G4}, 4'hF, -1, 16'h0, -1, 16'h0);
    check_frame("scan2",  {G1, G2, G3, G4}, 4'hF, -1, 16'h0, -1, 16'h0);
    check_frame("tear",   {G1, G2, G3, G4}, 4'hF,  6, 16'h5678, -1, 16'h0);
    check_frame("new",    {G5, G6, G7, G8}, 4'hF, -1, 16'h0, -1, 16'h0);
    check_frame("twold",  {G5, G6, G7, G8}, 4'hF,  3, 16'h2222, 9, 16'h9012);
    check_frame("second", {G9, G0, G1, G2}, 4'hF,  5, 16'h3456, 16, 16'h7890);
    check_frame("wrapld", {G3, G4, G5, G6}, 4'hF, -1, 16'h0, -1, 16'h0);
    check_frame("after",  {G7, G8, G9, G0}, 4'hF, -1, 16'h0, -1, 16'h0);

    blank_lz = 1'b1;
    load_word(16'h0040);
    check_frame("lz40", {GBL, GBL, G4, G0}, 4'hF, -1, 16'h0, -1, 16'h0);
    load_word(16'h0000);
    check_frame("lz00", {GBL, GBL, GBL, G0}, 4'hF, -1, 16'h0, -1, 16'h0);
    blank_lz = 1'b0;
    check_frame("nolz", {G0, G0, G0, G0}, 4'hF, -1, 16'h0, -1, 16'h0);

    load_word(16'hA0F9);
    check_frame("hex", {GA, G0, GF, G9}, 4'hF, -1, 16'h0, -1, 16'h0);

    dp_in = 4'b0100;
    load_word(16'h1234);
    check_frame("dp", {G1, G2, G3, G4}, 4'b1011, -1, 16'h0, -1, 16'h0);

    // Pending 8888 must be lost when reset lands in slot 2.
    wait_frame("rstw");
    load_word(16'h8888);
    repeat (9) tick();
    check("midscan.an", 32'(an), 32'b1011);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst   = 1'b0;
    dp_in = 4'b0000;
    check_frame("postrst", {G0, G0, G0, G0}, 4'hF, -1, 16'h0, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
